coin_acceptor: RTL
==================

# coin_acceptor

Coin-mechanism front end for the newspaper vending controller: the transmitting end of the `coin[1:0]` interface that the controller consumes. It synchronizes and debounces the raw nickel and dime sensors, and rejects simultaneous or overflow coins through `coin_return`. Accepted coins are queued in a 4-entry FIFO. Each queued coin is replayed to the controller as a clean one-hot-coded pulse with a guaranteed idle gap between pulses. It sits between the physical coin slot and the vending controller's `coin` input, and it watches the controller's `newspaper` output to avoid overlapping a vend.

## Interface
- `DEBOUNCE`, default 4: consecutive synchronized-high cycles required to qualify a coin, and consecutive low cycles required to re-arm that sensor. Legal range 2..15.
- `PULSE_LEN`, default 1: cycles that `coin` holds a nonzero code. Legal range 1..7.
- `GAP_LEN`, default 2: minimum cycles that `coin` is 0 after each pulse. Legal range 1..7.
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `nickel_in`  in  1  raw 5-cent sensor level; asynchronous.
- `dime_in`  in  1  raw 10-cent sensor level; asynchronous.
- `newspaper`  in  1  vend pulse from the controller.
- `coin`  out  2  registered code to the controller: 0 = none, 1 = 5 cents, 2 = 10 cents. The value 3 is never driven.
- `coin_return`  out  1  registered 1-cycle pulse; the coin is physically returned.
- `busy`  out  1  FIFO not empty or transmit FSM not in IDLE.
- `pending`  out  3  FIFO occupancy, 0..4.

## Operation
- **Synchronizer.** Each sensor passes through 2 flops; all later logic uses the second-stage value.
- **Debounce, per sensor.**
  - A counter counts consecutive synchronized-high cycles and saturates at `DEBOUNCE`.
  - The sensor qualifies on the edge where the count reaches `DEBOUNCE`, and only if the sensor is armed. Qualifying disarms the sensor.
  - `DEBOUNCE` consecutive low cycles re-arm it. A held-high sensor therefore yields exactly one coin.
  - Reset clears all counters and leaves both sensors disarmed. A sensor stuck high through reset never qualifies until it has been seen low for `DEBOUNCE` cycles.
- **Classification**, on a qualifying edge:
  - If both synchronized sensors are high, `coin_return` pulses, nothing is queued, and both sensors are disarmed.
  - Otherwise a nickel pushes 0 and a dime pushes 1.
  - If the FIFO is full, `coin_return` pulses and the coin is dropped; `pending` stays 4.
  - Two sensors qualifying on the same edge is handled as the both-high case.
- **FIFO.**
  - 4 entries, 1 bit each, with wrapping 2-bit pointers and a 3-bit count.
  - Push and pop on the same edge leave `pending` unchanged.
  - A push into an empty FIFO cannot be popped on that same edge.
- **Transmit FSM**, states IDLE, DRIVE, GAP:
  - IDLE: if the FIFO is not empty and `newspaper`=0, pop the head, load `coin` with 1 or 2, load the counter with `PULSE_LEN`, and go to DRIVE. Otherwise `coin`=0.
  - DRIVE: hold `coin` and decrement the counter. On the last cycle, set `coin`=0, load `GAP_LEN`, and go to GAP.
  - GAP: `coin`=0; decrement, then return to IDLE. If `newspaper`=1 in any GAP cycle, reload `GAP_LEN`, so the gap always ends `GAP_LEN` cycles after the last vend pulse.
- **Reset** has priority over everything and can arrive mid-pulse or mid-gap. On the next edge: `coin`=0, `coin_return`=0, `busy`=0, `pending`=0, FSM in IDLE, FIFO pointers 0, queued coins discarded.

## Timing
- Call edge 0 the first edge that samples a raw sensor high, with the sensor armed, FIFO empty and FSM in IDLE:
  - Edge `DEBOUNCE`+1: push; `pending`=1.
  - Edge `DEBOUNCE`+2: `coin` becomes nonzero and `pending`=0. This is edge 6 for the default `DEBOUNCE`=4.
- `coin_return` asserts on edge `DEBOUNCE`+1 for exactly one cycle.
- The spacing between the rising edges of consecutive `coin` pulses is at least `PULSE_LEN`+`GAP_LEN`+1 cycles: 4 at defaults.
  - The +1 is the IDLE decision cycle.
  - Back-to-back queued coins achieve exactly this spacing.
- `busy` is combinational from registered state; `pending` is registered state.

## Test plan
- **Single nickel.** Reset for 2 cycles, then `nickel_in`=1 for 10 cycles. Required: `coin`=1 for exactly 1 cycle starting at edge 6, and no second pulse.
- **Queue replay.** Three dimes, each 6 high and 6 low cycles. Required: three `coin`=2 pulses, `pending` never above 1, and `coin_return` never asserted.
- **Overflow.** Block IDLE by holding `newspaper`=1, then insert 5 nickels. Required: `pending`=4, and exactly one `coin_return` pulse on the 5th nickel. After releasing `newspaper`, four `coin`=1 pulses spaced 4 cycles apart.
- **Simultaneous sensors.** `nickel_in` and `dime_in` high together for 8 cycles. Required: one `coin_return` pulse, `coin` stays 0, `pending`=0.
- **Vend interlock.** Two nickels queued; `newspaper` pulses in the 1st GAP cycle after the first pulse. Required: the second `coin`=1 starts no earlier than 3 cycles after `newspaper`.
- **Reset mid-operation.** Assert `reset` during a DRIVE state with `pending`=2. Required: on the next edge `coin`=0, `pending`=0, `busy`=0. A sensor held high across the reset produces no coin until it has been low for 4 cycles.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: coin slot sensors and vend feedback in, replayed coin code and status out
interface coin_acceptor_if;
  logic       nickel_in;
  logic       dime_in;
  logic       newspaper;
  logic [1:0] coin;
  logic       coin_return;
  logic       busy;
  logic [2:0] pending;
  modport master (output nickel_in, dime_in, newspaper, input coin, coin_return, busy, pending);
  modport slave (input nickel_in, dime_in, newspaper, output coin, coin_return, busy, pending);
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces coin sensors, queues accepted coins and replays them as spaced one-hot pulses
module coin_acceptor #(
  parameter int DEBOUNCE  = 4,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 2
) (
  input logic            clock,
  input logic            reset,
  coin_acceptor_if.slave bus
);
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  localparam logic [2:0] PL = 3'(PULSE_LEN);
  localparam logic [2:0] GL = 3'(GAP_LEN);
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  logic [1:0][1:0] r_sync;
  logic [1:0][3:0] r_hi, r_lo;
  logic [1:0]      r_arm;
  logic [1:0]      w_s, w_raw, w_q;
  logic [3:0]      r_mem;
  logic [1:0]      r_wp, r_rp;
  logic [2:0]      r_cnt;
  logic            r_ret;
  state_t          r_state, w_state_nxt;
  logic [2:0]      r_tcnt, w_tcnt_nxt;
  logic [1:0]      r_coin, w_coin_nxt;
  logic            w_both, w_acc, w_full, w_push, w_pop;
  // index 0 is the nickel sensor, index 1 the dime sensor
  assign w_raw = {bus.dime_in, bus.nickel_in};
  for (genvar g = 0; g < 2; g++) begin : g_sense
    assign w_s[g] = r_sync[g][1];
    assign w_q[g] = r_arm[g] & w_s[g] & (r_hi[g] == DB - 4'd1);
  end
  assign w_both = (|w_q) & (&w_s);
  assign w_acc  = (|w_q) & ~w_both;
  assign w_full = r_cnt == 3'd4;
  assign w_push = w_acc & ~w_full;
  assign w_pop  = (r_state == IDLE) && (r_cnt != 3'd0) && !bus.newspaper;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_arm  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= {r_sync[i][0], w_raw[i]};
        r_hi[i]   <= !w_s[i] ? 4'd0 : (r_hi[i] == DB) ? DB : r_hi[i] + 4'd1;
        r_lo[i]   <= w_s[i] ? 4'd0 : (r_lo[i] == DB) ? DB : r_lo[i] + 4'd1;
        r_arm[i]  <= (w_q[i] | w_both) ? 1'b0 : (!w_s[i] && r_lo[i] == DB - 4'd1) ? 1'b1 : r_arm[i];
      end
    end
  end
  // a full FIFO rejects even if a pop happens on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ret <= 1'b0;
    end else begin
      if (w_push) r_mem[r_wp] <= w_q[1];
      r_wp  <= r_wp + 2'(w_push);
      r_rp  <= r_rp + 2'(w_pop);
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
      r_ret <= w_both | (w_acc & w_full);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_coin  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_coin  <= w_coin_nxt;
    end
  end
  always_comb begin
    w_state_nxt = (r_state == IDLE)  ? (w_pop ? DRIVE : IDLE)
                : (r_state == DRIVE) ? ((r_tcnt == 3'd1) ? GAP : DRIVE)
                : (!bus.newspaper && r_tcnt == 3'd1) ? IDLE : GAP;
  end
  // a vend seen during the gap restarts it
  always_comb begin
    w_tcnt_nxt = (r_state == IDLE)  ? PL
               : (r_state == DRIVE) ? ((r_tcnt == 3'd1) ? GL : r_tcnt - 3'd1)
               : bus.newspaper ? GL : r_tcnt - 3'd1;
    w_coin_nxt = (r_state == IDLE) ? (w_pop ? (r_mem[r_rp] ? 2'd2 : 2'd1) : 2'd0)
               : (r_state == DRIVE && r_tcnt != 3'd1) ? r_coin : 2'd0;
  end
  assign bus.coin        = r_coin;
  assign bus.coin_return = r_ret;
  assign bus.busy        = (r_cnt != 3'd0) || (r_state != IDLE);
  assign bus.pending     = r_cnt;
endmodule
